inst_fetch_ctrl: RTL and testbench

//  Instruction-fetch sequencer for the MIPS core. Owns the PC, drives the combinational

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_fifo.sv | 44 ++++
 rtl/inst_fetch_ctrl.sv | 110 +++++++++++
 tb/tb_inst_fetch_ctrl.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch sequencer: FSM states, widths and the
// {pc, inst} entry carried through the prefetch FIFO.
package fetch_pkg;

  localparam int          INST_W  = 32;
  localparam logic [31:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    FULL   = 2'd2,
    HALTED = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [31:0]       pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO of fetch entries with flush; push and pop may
// coincide when full because the slot being read out is freed that cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
)(
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_flush,
  input  logic         i_push,
  input  logic         i_pop,
  input  fetch_entry_t i_wdata,
  output fetch_entry_t o_rdata,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t   r_mem [DEPTH];
  logic [AW:0]    r_wptr;
  logic [AW:0]    r_rptr;

  // Extra pointer bit distinguishes full from empty when the index bits match.
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_rdata = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + (AW+1)'(1);
      if (i_pop)  r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push && !i_flush) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, reads imem combinationally and
// queues {pc, inst} for decode. Optional alignment/range fault: FETCH_ALIGN_CHECK_EN.
module inst_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter int          IMEM_WORDS = 4
)(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_halt,
  output logic [31:0]       o_imem_addr,
  input  logic [INST_W-1:0] i_imem_data,
  input  logic              i_redirect_valid,
  input  logic [31:0]       i_redirect_pc,
  output logic              o_id_valid,
  input  logic              i_id_ready,
  output logic [INST_W-1:0] o_id_inst,
  output logic [31:0]       o_id_pc,
  output logic [1:0]        o_fetch_state,
  output logic              o_fault
);

  fetch_state_t r_state, w_state_nxt;
  logic [31:0]  r_pc;
  logic         w_full, w_empty, w_pop, w_push, w_fetch_ok, w_fault_evt;
  fetch_entry_t w_wr_entry, w_rd_entry;

  assign w_pop      = !w_empty && i_id_ready;
  // A fetch slot exists in FETCH, or in FULL when the head leaves this cycle.
  assign w_fetch_ok = (r_state == FETCH || r_state == FULL) && !i_halt &&
                      !i_redirect_valid && (!w_full || w_pop);
  assign w_wr_entry = '{pc: r_pc, inst: i_imem_data};

`ifdef FETCH_ALIGN_CHECK_EN
  logic r_fault;
  logic w_oob;

  assign w_oob       = (r_pc >= 32'(PC_STEP * IMEM_WORDS));
  assign w_fault_evt = (i_redirect_valid && (i_redirect_pc[1:0] != 2'b00)) ||
                       (w_fetch_ok && w_oob);
  assign w_push      = w_fetch_ok && !w_oob && !r_fault;
  assign o_fault     = r_fault;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)         r_fault <= 1'b0;
    else if (w_fault_evt) r_fault <= 1'b1;
  end
`else
  logic w_unused_cfg;

  assign w_fault_evt  = 1'b0;
  assign w_push       = w_fetch_ok;
  assign o_fault      = 1'b0;
  assign w_unused_cfg = ^{i_redirect_pc[1:0], (IMEM_WORDS > 0)};
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      if (i_redirect_valid) r_pc <= {i_redirect_pc[31:2], 2'b00};
      else if (w_push)      r_pc <= r_pc + PC_STEP;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (i_en) w_state_nxt = FETCH;
      FETCH: begin
        if (i_halt)                                        w_state_nxt = HALTED;
        else if (w_full && !w_pop && !i_redirect_valid)    w_state_nxt = FULL;
      end
      FULL: begin
        if (i_halt)                         w_state_nxt = HALTED;
        else if (w_pop || i_redirect_valid) w_state_nxt = FETCH;
      end
      HALTED:  if (!i_halt) w_state_nxt = FETCH;
      default: w_state_nxt = IDLE;
    endcase
`ifdef FETCH_ALIGN_CHECK_EN
    if (r_fault) w_state_nxt = HALTED;
`endif
    if (w_fault_evt) w_state_nxt = HALTED;
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_flush (i_redirect_valid),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_wr_entry),
    .o_rdata (w_rd_entry),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign o_imem_addr   = r_pc;
  assign o_fetch_state = r_state;
  assign o_id_valid    = !w_empty;
  assign o_id_inst     = w_empty ? '0 : w_rd_entry.inst;
  assign o_id_pc       = w_empty ? '0 : w_rd_entry.pc;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl: fetch stream, back-pressure, redirect,
// halt, reset, and the alignment fault when FETCH_ALIGN_CHECK_EN is defined.
module tb_inst_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, en, halt, redirect_valid, id_ready;
  logic [31:0] redirect_pc, imem_addr, imem_data, id_inst, id_pc;
  logic        id_valid, fault;
  logic [1:0]  fetch_state;

  int n_pass = 0;
  int n_tot  = 0;

`ifdef FETCH_ALIGN_CHECK_EN
  localparam int          IMW      = 1024;
  localparam logic [31:0] HALT_RED = 32'h0000_0028;
`else
  localparam int          IMW      = 4;
  localparam logic [31:0] HALT_RED = 32'h0000_002B;
`endif

  always #5 clk = ~clk;

  // Instruction memory model: word content is derived from its address.
  assign imem_data = {16'hC0DE, imem_addr[15:0]};

  inst_fetch_ctrl #(.RESET_PC(32'h0), .FIFO_DEPTH(2), .IMEM_WORDS(IMW)) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_en             (en),
    .i_halt           (halt),
    .o_imem_addr      (imem_addr),
    .i_imem_data      (imem_data),
    .i_redirect_valid (redirect_valid),
    .i_redirect_pc    (redirect_pc),
    .o_id_valid       (id_valid),
    .i_id_ready       (id_ready),
    .o_id_inst        (id_inst),
    .o_id_pc          (id_pc),
    .o_fetch_state    (fetch_state),
    .o_fault          (fault)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chk_head(input string tag, input logic [31:0] pc);
    chk({tag, "_vld"},  32'(id_valid), 32'd1);
    chk({tag, "_pc"},   id_pc, pc);
    chk({tag, "_inst"}, id_inst, {16'hC0DE, pc[15:0]});
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; halt = 1'b0; id_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    tick(); tick();
    chk("rst_vld",   32'(id_valid), 32'd0);
    chk("rst_pc",    id_pc, 32'd0);
    chk("rst_inst",  id_inst, 32'd0);
    chk("rst_state", 32'(fetch_state), 32'd0);
    chk("rst_addr",  imem_addr, 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);

    // start streaming
    rst_n = 1'b1; en = 1'b1; id_ready = 1'b1;
    tick();
    chk("en_state", 32'(fetch_state), 32'd1);
    chk("en_vld0",  32'(id_valid), 32'd0);
    en = 1'b0;
    tick(); chk_head("s0", 32'h0); chk("s0_addr", imem_addr, 32'h4);
    tick(); chk_head("s4", 32'h4);
    tick(); chk_head("s8", 32'h8);

    // back-pressure: FIFO fills, FSM parks in FULL, head frozen
    id_ready = 1'b0;
    tick(); chk_head("bp0", 32'h8); chk("bp0_state", 32'(fetch_state), 32'd1);
    tick(); chk("bp1_state", 32'(fetch_state), 32'd2); chk("bp1_addr", imem_addr, 32'h10);
    tick(); tick(); tick();
    chk_head("bp4", 32'h8);
    chk("bp4_state", 32'(fetch_state), 32'd2);
    chk("bp4_addr",  imem_addr, 32'h10);
    id_ready = 1'b1;
    tick(); chk_head("rel0", 32'hC); chk("rel0_state", 32'(fetch_state), 32'd1);
    tick(); chk_head("rel1", 32'h10);
    tick(); chk_head("rel2", 32'h14);

    // redirect to 0 and fill FIFO with pc 0,4
    id_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0;
    tick(); chk("rd0_vld", 32'(id_valid), 32'd0); chk("rd0_addr", imem_addr, 32'h0);
    redirect_valid = 1'b0;
    tick(); tick(); tick();
    chk_head("fill", 32'h0);
    chk("fill_state", 32'(fetch_state), 32'd2);

    // redirect to 8 while full
    redirect_valid = 1'b1; redirect_pc = 32'h8;
    tick();
    chk("rd8_vld",   32'(id_valid), 32'd0);
    chk("rd8_state", 32'(fetch_state), 32'd1);
    redirect_valid = 1'b0; id_ready = 1'b1;
    tick(); chk_head("rd8", 32'h8); chk("rd8_addr", imem_addr, 32'hC);

    // halt: FIFO drains, pc holds; redirect while halted moves pc only
    halt = 1'b1;
    tick(); chk("h0_vld", 32'(id_valid), 32'd0); chk("h0_state", 32'(fetch_state), 32'd3);
    tick(); chk("h1_addr", imem_addr, 32'hC);
    redirect_valid = 1'b1; redirect_pc = HALT_RED;
    tick(); chk("h2_addr", imem_addr, 32'h28); chk("h2_state", 32'(fetch_state), 32'd3);
    redirect_valid = 1'b0;
    tick(); chk("h3_addr", imem_addr, 32'h28); chk("h3_vld", 32'(id_valid), 32'd0);
    halt = 1'b0;
    tick(); chk("hr_state", 32'(fetch_state), 32'd1); chk("hr_addr", imem_addr, 32'h28);
    tick(); chk_head("hr", 32'h28); chk("hr_addr2", imem_addr, 32'h2C);

    // reset with full FIFO
    id_ready = 1'b0;
    tick(); chk_head("pre_rst", 32'h28);
    rst_n = 1'b0;
    tick();
    chk("mr_vld",   32'(id_valid), 32'd0);
    chk("mr_addr",  imem_addr, 32'h0);
    chk("mr_state", 32'(fetch_state), 32'd0);
    chk("mr_pc",    id_pc, 32'd0);
    rst_n = 1'b1;

    // redirect in IDLE: pc moves, state stays
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    tick(); chk("ri_addr", imem_addr, 32'h40); chk("ri_state", 32'(fetch_state), 32'd0);

    redirect_pc = 32'h6;
    tick();
`ifdef FETCH_ALIGN_CHECK_EN
    chk("flt_set",   32'(fault), 32'd1);
    chk("flt_state", 32'(fetch_state), 32'd3);
    redirect_valid = 1'b0; en = 1'b1;
    tick(); tick();
    chk("flt_hold",  32'(fault), 32'd1);
    chk("flt_hst",   32'(fetch_state), 32'd3);
    chk("flt_vld",   32'(id_valid), 32'd0);
    rst_n = 1'b0; en = 1'b0;
    tick();
    chk("flt_clr",   32'(fault), 32'd0);
    chk("flt_cst",   32'(fetch_state), 32'd0);
`else
    chk("lowclr_addr",  imem_addr, 32'h4);
    chk("lowclr_fault", 32'(fault), 32'd0);
    chk("lowclr_state", 32'(fetch_state), 32'd0);
`endif
    redirect_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
